// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NREQ byte producers.
// Each grant runs LOAD (strobe byte) -> SEND (T_Byte for FRAME_CLKS) -> GAP -> IDLE.
module uart_tx_arbiter #(
  parameter int NREQ       = 4,
  parameter int FRAME_CLKS = 200,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW = $clog2(FRAME_CLKS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        Data_In,
  output logic              Byte_ready,
  output logic              T_Byte,
  output logic              busy,
  output logic [IW-1:0]     grant_id
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] ptr;
  logic [IW-1:0] win;
  logic [CW-1:0] cnt;
  logic [7:0]    data_q;
  logic [7:0]    slot [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      slot[i] = req_data[8*i +: 8];
    end
  end

  // Lowest requester above ptr wins; if none, the lowest requester overall (wrap).
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) win = IW'(i);
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && (i > int'(ptr))) win = IW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|req) state_next = LOAD;
      LOAD:    state_next = SEND;
      SEND:    if (cnt == '0) state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr    <= IW'(NREQ - 1);
      data_q <= 8'h00;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            ptr    <= win;
            data_q <= slot[win];
          end
        end
        LOAD: cnt <= CW'(FRAME_CLKS - 1);
        SEND: if (cnt != '0) cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Outputs decode straight from registered state so reset clears them without a clock.
  always_comb begin
    ack        = '0;
    busy       = (state != IDLE);
    Byte_ready = (state == LOAD);
    T_Byte     = (state == SEND);
    if (state == LOAD) ack[ptr] = 1'b1;
  end

  assign Data_In  = data_q;
  assign grant_id = ptr;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected grants are queued when requests are
// driven and popped when ack appears; a second instance covers NREQ=2, FRAME_CLKS=1.
module tb_uart_tx_arbiter;

  localparam int NREQ   = 4;
  localparam int FRAME  = 200;
  localparam int PERIOD = FRAME + 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   ack;
  logic [7:0]        data_in;
  logic              byte_ready;
  logic              t_byte;
  logic              busy;
  logic [1:0]        grant_id;

  logic [1:0]  req2 = '0;
  logic [15:0] req_data2 = 16'h5B5A;
  logic [1:0]  ack2;
  logic [7:0]  data_in2;
  logic        byte_ready2;
  logic        t_byte2;
  logic        busy2;
  logic        grant_id2;

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t sb2[$];
  int   ack_cyc[$];
  int   ack2_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   hi_cnt = 0;
  int   hi2_cnt = 0;
  int   last_hi_cyc = 0;
  int   tb_ptr = NREQ - 1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_tx_arbiter #(.NREQ(NREQ), .FRAME_CLKS(FRAME)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .Data_In(data_in), .Byte_ready(byte_ready), .T_Byte(t_byte),
    .busy(busy), .grant_id(grant_id)
  );

  uart_tx_arbiter #(.NREQ(2), .FRAME_CLKS(1)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .req_data(req_data2), .ack(ack2),
    .Data_In(data_in2), .Byte_ready(byte_ready2), .T_Byte(t_byte2),
    .busy(busy2), .grant_id(grant_id2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Main monitor: overlap rule, T_Byte width, scoreboard pop on ack, requester drops req.
  always @(negedge clk) begin
    exp_t e;
    checkOutput("no_overlap", 32'(byte_ready & t_byte), 0);
    if (!rst) hi_cnt = 0;
    else if (t_byte) begin
      hi_cnt++;
      last_hi_cyc = cyc;
    end else if (hi_cnt != 0) begin
      checkOutput("t_byte_len", hi_cnt, FRAME);
      hi_cnt = 0;
    end
    if (ack != '0) begin
      if (sb.size() == 0) checkOutput("spurious_ack", 32'(ack), 0);
      else begin
        e = sb.pop_front();
        checkOutput("ack_onehot", 32'(ack), 32'(1) << e.id);
        checkOutput("data_in", 32'(data_in), 32'(e.data));
        checkOutput("grant_id", 32'(grant_id), e.id);
        checkOutput("byte_ready_with_ack", 32'(byte_ready), 1);
        checkOutput("t_byte_low_in_load", 32'(t_byte), 0);
      end
      ack_cyc.push_back(cyc);
      req = req & ~ack;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    checkOutput("no_overlap2", 32'(byte_ready2 & t_byte2), 0);
    if (!rst) hi2_cnt = 0;
    else if (t_byte2) hi2_cnt++;
    else if (hi2_cnt != 0) begin
      checkOutput("t_byte_len2", hi2_cnt, 1);
      hi2_cnt = 0;
    end
    if (ack2 != '0) begin
      if (sb2.size() == 0) checkOutput("spurious_ack2", 32'(ack2), 0);
      else begin
        e = sb2.pop_front();
        checkOutput("ack2_onehot", 32'(ack2), 32'(1) << e.id);
        checkOutput("data_in2", 32'(data_in2), 32'(e.data));
        checkOutput("grant_id2", 32'(grant_id2), e.id);
        if (sb2.size() == 0) req2 = '0;
      end
      ack2_cyc.push_back(cyc);
    end
  end

  // Drives a request set and queues the grants round-robin order predicts.
  task automatic applyStimulus(input logic [NREQ-1:0] mask, input logic [8*NREQ-1:0] bytes,
                               output int start_cyc);
    exp_t e;
    int   last;
    @(negedge clk);
    #1;
    last = -1;
    for (int i = 0; i < NREQ; i++) begin
      if (mask[i]) req_data[8*i +: 8] = bytes[8*i +: 8];
    end
    for (int k = 1; k <= NREQ; k++) begin
      int id;
      id = (tb_ptr + k) % NREQ;
      if (mask[id]) begin
        e.id   = id;
        e.data = bytes[8*id +: 8];
        sb.push_back(e);
        last = id;
      end
    end
    if (last >= 0) tb_ptr = last;
    req = req | mask;
    start_cyc = cyc;
  endtask

  task automatic waitDrain(input string tag, input int maxc);
    int n = 0;
    while (sb.size() != 0 && n < maxc) begin
      @(negedge clk);
      #2;
      n++;
    end
    checkOutput(tag, sb.size(), 0);
  endtask

  task automatic waitIdle(input string tag, input int maxc);
    int n = 0;
    while (busy && n < maxc) begin
      @(negedge clk);
      #2;
      n++;
    end
    checkOutput(tag, 32'(busy), 0);
  endtask

  task automatic waitTByte(input string tag, input int maxc);
    int n = 0;
    while (!t_byte && n < maxc) begin
      @(negedge clk);
      #2;
      n++;
    end
    checkOutput(tag, 32'(t_byte), 1);
  endtask

  task automatic doReset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    tb_ptr = NREQ - 1;
  endtask

  initial begin
    int c0;
    exp_t e;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_ack", 32'(ack), 0);
    checkOutput("rst_byte_ready", 32'(byte_ready), 0);
    checkOutput("rst_t_byte", 32'(t_byte), 0);
    checkOutput("rst_data_in", 32'(data_in), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_grant_id", 32'(grant_id), NREQ - 1);
    rst = 1'b1;

    $display("[TB] single request, byte 8'h24");
    ack_cyc.delete();
    applyStimulus(4'b0001, 32'h0000_0024, c0);
    waitDrain("t1_drain", 20);
    checkOutput("t1_grant_latency", (ack_cyc.size() > 0) ? ack_cyc[0] - c0 : -1, 1);
    waitIdle("t1_idle", PERIOD + 10);
    checkOutput("t1_busy_fall", cyc - last_hi_cyc, 2);
    checkOutput("t1_data_hold", 32'(data_in), 32'h24);

    $display("[TB] all four requesting after reset");
    doReset();
    ack_cyc.delete();
    applyStimulus(4'b1111, 32'hA3A2_A1A0, c0);
    waitDrain("t2_drain", 4 * PERIOD + 20);
    checkOutput("t2_ack_count", ack_cyc.size(), 4);
    for (int i = 1; i < ack_cyc.size(); i++) checkOutput("t2_spacing", ack_cyc[i] - ack_cyc[i-1], PERIOD);
    waitIdle("t2_idle", PERIOD + 10);

    $display("[TB] late request during SEND");
    ack_cyc.delete();
    applyStimulus(4'b0001, 32'h0000_00C0, c0);
    waitTByte("t3_send", 10);
    repeat (48) @(negedge clk);
    applyStimulus(4'b0100, 32'h00C2_0000, c0);
    waitDrain("t3_drain", 2 * PERIOD + 10);
    checkOutput("t3_ack_after_fall", (ack_cyc.size() == 2) ? ack_cyc[1] - last_hi_cyc : -1, 3);
    waitIdle("t3_idle", PERIOD + 10);

    $display("[TB] withdrawn pulse and Data_In hold");
    applyStimulus(4'b0001, 32'h0000_00B5, c0);
    waitDrain("t4_drain", 20);
    req_data[7:0] = 8'hFF;
    waitTByte("t4_send", 10);
    repeat (20) @(negedge clk);
    #1;
    req[1] = 1'b1;
    req_data[15:8] = 8'h77;
    @(negedge clk);
    #1;
    req[1] = 1'b0;
    waitIdle("t4_idle", PERIOD + 10);
    repeat (5) @(negedge clk);
    #1;
    checkOutput("t4_busy_stays_low", 32'(busy), 0);
    checkOutput("t4_data_hold", 32'(data_in), 32'hB5);
    checkOutput("t4_grant_id", 32'(grant_id), 0);

    $display("[TB] reset in the middle of SEND");
    applyStimulus(4'b0001, 32'h0000_003C, c0);
    waitDrain("t5_drain", 20);
    waitTByte("t5_send", 10);
    repeat (100) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("t5_t_byte_async", 32'(t_byte), 0);
    checkOutput("t5_busy_async", 32'(busy), 0);
    checkOutput("t5_byte_ready_async", 32'(byte_ready), 0);
    checkOutput("t5_data_in_async", 32'(data_in), 0);
    checkOutput("t5_grant_id_async", 32'(grant_id), NREQ - 1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    tb_ptr = NREQ - 1;
    applyStimulus(4'b0110, 32'h00E2_E100, c0);
    waitDrain("t5_post_drain", 2 * PERIOD + 10);
    waitIdle("t5_idle", PERIOD + 10);

    $display("[TB] NREQ=2 FRAME_CLKS=1 alternation");
    @(negedge clk);
    #1;
    ack2_cyc.delete();
    for (int k = 0; k < 4; k++) begin
      e.id   = k % 2;
      e.data = (k % 2 == 0) ? 8'h5A : 8'h5B;
      sb2.push_back(e);
    end
    req2 = 2'b11;
    for (int n = 0; n < 40 && sb2.size() != 0; n++) begin
      @(negedge clk);
      #2;
    end
    checkOutput("t6_drain", sb2.size(), 0);
    checkOutput("t6_ack_count", ack2_cyc.size(), 4);
    for (int i = 1; i < ack2_cyc.size(); i++) checkOutput("t6_period", ack2_cyc[i] - ack2_cyc[i-1], 4);
    repeat (6) @(negedge clk);
    #1;
    checkOutput("t6_idle", 32'(busy2), 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares the single UART transmitter (`toplevel`) between `NREQ` byte producers. It accepts requests, selects one, captures its byte, and drives the transmitter's `Data_In`/`Byte_ready`/`T_Byte` load-then-transmit sequence. It then holds the transmitter for a fixed frame time before granting the next requester. It sits directly in front of `toplevel`; `Tx` is not routed through this block.

## Interface

- `NREQ`, 4, number of requesters (2..8)
- `FRAME_CLKS`, 200, clock cycles `T_Byte` is held high per byte; must cover start + 8 data + stop bits at the transmitter's baud rate (≥1)

- `clk`  in  1  single system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low (0 = reset)
- `req`  in  `NREQ`  per-requester byte request; level, held until `ack`
- `req_data`  in  `8*NREQ`  byte for requester i at bits [8i+7:8i]; stable while `req[i]`=1
- `ack`  out  `NREQ`  one-cycle pulse: byte of requester i captured
- `Data_In`  out  8  byte to transmitter
- `Byte_ready`  out  1  transmitter load strobe
- `T_Byte`  out  1  transmitter send enable
- `busy`  out  1  1 whenever state ≠ IDLE
- `grant_id`  out  `$clog2(NREQ)`  index of last granted requester

## Operation

- States: IDLE, LOAD, SEND, GAP.
- IDLE: if `req`≠0, select the winner by round-robin, searching from `ptr+1` upward with wrap to 0. On that edge:
  - `ptr`←winner, `grant_id`←winner
  - `Data_In`←winner's `req_data` slice
  - `ack[winner]`←1, `Byte_ready`←1
  - state←LOAD
- LOAD (1 cycle): `Byte_ready`=1, `T_Byte`=0. Next edge: `Byte_ready`←0, `T_Byte`←1, counter←`FRAME_CLKS`-1, state←SEND.
- SEND: `T_Byte`=1. Counter decrements each edge. On the edge where counter=0: `T_Byte`←0, state←GAP.
- GAP (1 cycle, `T_Byte`=0, guarantees a low gap between frames): next edge state←IDLE.
- `ack` and `Byte_ready` are registered, high only in the LOAD cycle.
- `Data_In` holds the captured byte until the next grant; it does not follow `req_data`.
- `req` is sampled only in IDLE. A requester that drops `req` before `ack` is withdrawn without side effect.
- Requests arriving during LOAD/SEND/GAP wait. Fairness: with all requesters active, grants cycle 0,1,…,NREQ-1,0,…
- Counter width: `$clog2(FRAME_CLKS+1)`, no wrap; `FRAME_CLKS`=1 gives a single SEND cycle.
- Reset (any time, including mid-SEND) forces the values below immediately. The transmitter sees `T_Byte` fall and aborts per its own rules.
  - state=IDLE, `ptr`=`NREQ`-1 (requester 0 wins first)
  - `ack`=0, `Byte_ready`=0, `T_Byte`=0, `Data_In`=8'h00, `busy`=0, `grant_id`=`NREQ`-1, counter=0

## Timing

- `req` high at edge k (state IDLE) → `ack`/`Byte_ready` high in cycle k..k+1 → `T_Byte` high from edge k+1 for exactly `FRAME_CLKS` cycles → GAP → IDLE.
- Per-byte occupancy: `FRAME_CLKS`+3 cycles, including one IDLE sample cycle. Back-to-back throughput is one byte per `FRAME_CLKS`+3 cycles.
- Grant latency from IDLE: 1 edge. Worst-case wait for a requester: (`NREQ`-1)·(`FRAME_CLKS`+3)+1 cycles.
- `Byte_ready` and `T_Byte` are never high in the same cycle.
- `Data_In` is stable from LOAD through the end of GAP.

## Test plan

- Reset, then `req`=4'b0001 with byte 8'h24 held until `ack` → `ack`=4'b0001 for 1 cycle, `Data_In`=8'h24 with `Byte_ready`=1 in the same cycle, `T_Byte` high exactly 200 cycles, `busy` low 2 cycles after `T_Byte` falls, `Tx` shows frame 0-00100100-1 (LSB first).
- `req`=4'b1111 held, bytes 8'hA0..8'hA3, each requester dropping `req` after its `ack` → grants 0,1,2,3 in order, `ack` pulses spaced 203 cycles apart.
- Requester 2 asserts `req` at the 50th cycle of SEND for requester 0 → no `ack` until IDLE; `ack[2]` exactly 3 cycles after `T_Byte` falls.
- `req[1]` pulses for one cycle during SEND and is gone by IDLE → no grant; `busy` stays 0.
- `rst`=0 asserted 100 cycles into SEND → `T_Byte`, `busy`, `Byte_ready` drop in the same cycle with no clock edge required. After release, `req`=4'b0110 → requester 1 granted first.
- `FRAME_CLKS`=1, `NREQ`=2, both requesting → `T_Byte` one cycle per byte, grant alternation 0,1,0,1, period 4 cycles.
